sram_ctrl_fsm: RTL and testbench

SRAM_CTRL_FSM -- requirements
Module: sram_ctrl_fsm

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_ctrl_counter.sv | 27 ++
 rtl/sram_ctrl_fsm.sv | 166 ++++++++++++++++
 tb/tb_sram_ctrl_fsm.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types for the SRAM controller: command opcodes, FSM states and widths.
package sram_ctrl_pkg;

  localparam int unsigned STATE_WIDTH = 3;
  // Wide enough for READ_LATENCY up to 4 and WAKE_CYCLES up to 15.
  localparam int unsigned CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_SLEEP = 2'd2,
    OP_WAKE  = 2'd3
  } op_e;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE      = 3'd0,
    ST_READ_WAIT = 3'd1,
    ST_RESP      = 3'd2,
    ST_SLEEP     = 3'd3,
    ST_WAKING    = 3'd4
  } state_e;

endpackage

// File: rtl/sram_ctrl_counter.sv
// Loadable down-counter shared by the read-latency and wake-up waits.
module sram_ctrl_counter
  import sram_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 dec,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_ctrl_fsm.sv
// SRAM access controller: write/read/sleep/wake command FSM with registered
// SRAM strobes and a single-entry read response holding register.
module sram_ctrl_fsm
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WAKE_CYCLES  = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [DATA_WIDTH-1:0]  cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   mem_cen,
  output logic                   mem_wen,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic                   mem_sleep,
  output logic                   err,
  output logic [2:0]             current_state
);

  state_e                 state, state_next;
  op_e                    op;
  logic                   accept;
  logic                   cen_next, wen_next, sleep_next, err_next, rsp_valid_next;
  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [DATA_WIDTH-1:0]  wdata_next, rsp_data_next;
  logic                   cnt_load, cnt_dec, cnt_done;
  logic [CNT_WIDTH-1:0]   cnt_val;

  assign cmd_ready     = !RESET && ((state == ST_IDLE) || (state == ST_SLEEP));
  assign accept        = cmd_valid && cmd_ready;
  assign op            = op_e'(cmd_op);
  assign current_state = state;

  sram_ctrl_counter u_counter (
    .clk      (CLK),
    .rst      (RESET),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_next     = state;
    cen_next       = 1'b0;
    wen_next       = 1'b0;
    addr_next      = mem_addr;
    wdata_next     = mem_wdata;
    sleep_next     = mem_sleep;
    err_next       = 1'b0;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    cnt_load       = 1'b0;
    cnt_val        = '0;
    cnt_dec        = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_WRITE: begin
              cen_next   = 1'b1;
              wen_next   = 1'b1;
              addr_next  = cmd_addr;
              wdata_next = cmd_wdata;
            end
            OP_READ: begin
              cen_next   = 1'b1;
              addr_next  = cmd_addr;
              state_next = ST_READ_WAIT;
              // Count starts at READ_LATENCY so capture lands READ_LATENCY cycles after the strobe.
              cnt_load   = 1'b1;
              cnt_val    = CNT_WIDTH'(READ_LATENCY);
            end
            OP_SLEEP: begin
              sleep_next = 1'b1;
              state_next = ST_SLEEP;
            end
            OP_WAKE: ;
          endcase
        end
      end

      ST_READ_WAIT: begin
        if (cnt_done) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = mem_rdata;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end

      ST_SLEEP: begin
        if (accept) begin
          case (op)
            OP_WAKE: begin
              sleep_next = 1'b0;
              state_next = ST_WAKING;
              cnt_load   = 1'b1;
              cnt_val    = CNT_WIDTH'(WAKE_CYCLES - 1);
            end
            OP_SLEEP: ;
            default:  err_next = 1'b1;
          endcase
        end
      end

      ST_WAKING: begin
        if (cnt_done) begin
          state_next = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_next     = ST_IDLE;
        rsp_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      mem_cen   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_sleep <= 1'b0;
      err       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state     <= state_next;
      mem_cen   <= cen_next;
      mem_wen   <= wen_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      mem_sleep <= sleep_next;
      err       <= err_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
    end
  end

endmodule

// File: tb/tb_sram_ctrl_fsm.sv
// Randomized self-checking bench for sram_ctrl_fsm with a timestamp-based
// behavioural model, an SRAM model, and literal directed checks.
module tb_sram_ctrl_fsm;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int RL = 2;
  localparam int WC = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          mem_cen;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_sleep;
  logic          err;
  logic [2:0]    current_state;

  always #5 CLK = ~CLK;

  sram_ctrl_fsm #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .READ_LATENCY (RL),
    .WAKE_CYCLES  (WC)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .mem_cen       (mem_cen),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_sleep     (mem_sleep),
    .err           (err),
    .current_state (current_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endfunction

  // Behavioural model: st is the externally visible state code; waits are
  // expressed as absolute cycle numbers derived from acceptance time.
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  int            st = 0;
  int            resp_at, idle_at;
  logic [DW-1:0] rd_val;
  bit            m_acc;
  bit            chk_en = 1'b0;
  logic          e_cen, e_wen, e_sleep, e_err, e_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;

  always @(posedge CLK) begin
    m_acc = cmd_valid && !RESET && (st == 0 || st == 3);
    cyc++;
    e_cen = 1'b0;
    e_wen = 1'b0;
    e_err = 1'b0;
    if (RESET) begin
      st      = 0;
      e_rv    = 1'b0;
      e_rdata = '0;
      e_addr  = '0;
      e_wdata = '0;
      e_sleep = 1'b0;
    end else begin
      case (st)
        0: if (m_acc) begin
          case (cmd_op)
            2'd0: begin
              e_cen = 1'b1; e_wen = 1'b1; e_addr = cmd_addr; e_wdata = cmd_wdata;
              m_mem[cmd_addr] = cmd_wdata;
            end
            2'd1: begin
              e_cen = 1'b1; e_addr = cmd_addr; rd_val = m_mem[cmd_addr];
              resp_at = (cyc - 1) + 2 + RL;
              st = 1;
            end
            2'd2: begin e_sleep = 1'b1; st = 3; end
            default: ;
          endcase
        end
        1: if (cyc == resp_at) begin st = 2; e_rv = 1'b1; e_rdata = rd_val; end
        2: if (rsp_ready) begin st = 0; e_rv = 1'b0; end
        3: if (m_acc) begin
          if (cmd_op == 2'd3) begin
            e_sleep = 1'b0; st = 4; idle_at = (cyc - 1) + WC + 1;
          end else if (cmd_op != 2'd2) begin
            e_err = 1'b1;
          end
        end
        4: if (cyc == idle_at) st = 0;
        default: st = 0;
      endcase
    end
    chk_en = 1'b1;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(!RESET && (st == 0 || st == 3)));
      chk("state",     32'(current_state), 32'(st));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_data",  32'(rsp_data),  32'(e_rdata));
      chk("mem_cen",   32'(mem_cen),   32'(e_cen));
      chk("mem_wen",   32'(mem_wen),   32'(e_wen));
      chk("mem_sleep", 32'(mem_sleep), 32'(e_sleep));
      chk("err",       32'(err),       32'(e_err));
      if (e_cen) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_cen && e_wen) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    end
  end

  // SRAM model: read data is valid only in the cycle READ_LATENCY after the
  // strobe; every other cycle carries random garbage.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  bit            pend = 1'b0;
  int            pend_at;
  logic [DW-1:0] pend_data;

  always @(negedge CLK) begin
    if (pend && cyc == pend_at) begin
      mem_rdata = pend_data;
      pend      = 1'b0;
    end else begin
      mem_rdata = DW'($urandom);
    end
    if (mem_cen === 1'b1 && mem_wen === 1'b1) sram[mem_addr] = mem_wdata;
    if (mem_cen === 1'b1 && mem_wen === 1'b0) begin
      pend      = 1'b1;
      pend_at   = cyc + RL;
      pend_data = sram[mem_addr];
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    cmd_valid = v;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      m_mem[i] = '0;
      sram[i]  = '0;
    end
    RESET     = 1'b1;
    rsp_ready = 1'b0;
    drive(0, 2'd0, '0, '0);
    repeat (3) step();
    @(negedge CLK);
    chk("rst_ready",     32'(cmd_ready), 32'd0);
    chk("rst_state",     32'(current_state), 32'd0);
    chk("rst_cen",       32'(mem_cen), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data), 32'd0);
    chk("rst_addr",      32'(mem_addr), 32'd0);
    chk("rst_sleep",     32'(mem_sleep), 32'd0);
    step(); RESET = 1'b0;
    step();

    // Single write, strobe in the following cycle only.
    step(); drive(1, 2'd0, 9'h005, 16'hBEEF);
    @(negedge CLK); chk("w_ready", 32'(cmd_ready), 32'd1);
    step(); drive(0, 2'd0, '0, '0);
    @(negedge CLK);
    chk("w_cen", 32'(mem_cen), 32'd1);
    chk("w_wen", 32'(mem_wen), 32'd1);
    chk("w_addr", 32'(mem_addr), 32'h005);
    chk("w_wdata", 32'(mem_wdata), 32'hBEEF);
    step(); @(negedge CLK); chk("w_cen_drop", 32'(mem_cen), 32'd0);

    // Read with response back-pressure.
    step(); drive(1, 2'd1, 9'h005, '0); rsp_ready = 1'b0;
    step(); drive(0, 2'd0, '0, '0);
    @(negedge CLK);
    chk("r_cen", 32'(mem_cen), 32'd1);
    chk("r_wen", 32'(mem_wen), 32'd0);
    chk("r_state", 32'(current_state), 32'd1);
    step(); @(negedge CLK); chk("r_no_rsp2", 32'(rsp_valid), 32'd0);
    step(); @(negedge CLK); chk("r_no_rsp3", 32'(rsp_valid), 32'd0);
    step(); @(negedge CLK);
    chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("r_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("r_resp_state", 32'(current_state), 32'd2);
    for (int i = 0; i < 2; i++) begin
      step(); @(negedge CLK);
      chk("r_hold_valid", 32'(rsp_valid), 32'd1);
      chk("r_hold_data", 32'(rsp_data), 32'hBEEF);
    end
    step(); rsp_ready = 1'b1;
    @(negedge CLK); chk("r_hs_valid", 32'(rsp_valid), 32'd1);
    step(); rsp_ready = 1'b0;
    @(negedge CLK);
    chk("r_idle", 32'(current_state), 32'd0);
    chk("r_valid_drop", 32'(rsp_valid), 32'd0);
    chk("r_data_keep", 32'(rsp_data), 32'hBEEF);
    chk("r_ready_back", 32'(cmd_ready), 32'd1);

    // Sleep, dropped write, wake.
    step(); drive(1, 2'd2, '0, '0);
    step(); drive(1, 2'd0, 9'h001, 16'h1234);
    @(negedge CLK);
    chk("s_state", 32'(current_state), 32'd3);
    chk("s_sleep", 32'(mem_sleep), 32'd1);
    step(); drive(0, 2'd0, '0, '0);
    @(negedge CLK);
    chk("s_err", 32'(err), 32'd1);
    chk("s_no_cen", 32'(mem_cen), 32'd0);
    chk("s_state_keep", 32'(current_state), 32'd3);
    step(); @(negedge CLK); chk("s_err_clear", 32'(err), 32'd0);
    step(); drive(1, 2'd3, '0, '0);
    step(); drive(0, 2'd0, '0, '0);
    for (int i = 0; i < WC; i++) begin
      @(negedge CLK);
      chk("k_waking", 32'(current_state), 32'd4);
      chk("k_ready_low", 32'(cmd_ready), 32'd0);
      chk("k_sleep_off", 32'(mem_sleep), 32'd0);
      step();
    end
    @(negedge CLK);
    chk("k_idle", 32'(current_state), 32'd0);
    chk("k_ready", 32'(cmd_ready), 32'd1);

    // Back-to-back writes.
    step(); drive(1, 2'd0, 9'd0, 16'h1111);
    step(); drive(1, 2'd0, 9'd1, 16'h2222);
    @(negedge CLK); chk("b_cen0", 32'(mem_cen), 32'd1); chk("b_addr0", 32'(mem_addr), 32'd0);
    step(); drive(1, 2'd0, 9'd2, 16'h3333);
    @(negedge CLK); chk("b_cen1", 32'(mem_cen), 32'd1); chk("b_addr1", 32'(mem_addr), 32'd1);
    step(); drive(0, 2'd0, '0, '0);
    @(negedge CLK); chk("b_cen2", 32'(mem_cen), 32'd1); chk("b_addr2", 32'(mem_addr), 32'd2);
    step(); @(negedge CLK); chk("b_cen_end", 32'(mem_cen), 32'd0);

    // Reset while a read is outstanding.
    step(); drive(1, 2'd1, 9'd3, '0);
    step(); drive(0, 2'd0, '0, '0);
    @(negedge CLK); chk("x_wait", 32'(current_state), 32'd1);
    step(); RESET = 1'b1;
    @(negedge CLK); chk("x_ready_rst", 32'(cmd_ready), 32'd0);
    step(); RESET = 1'b0;
    @(negedge CLK); chk("x_idle", 32'(current_state), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(); @(negedge CLK);
      chk("x_no_rsp", 32'(rsp_valid), 32'd0);
      chk("x_ready", 32'(cmd_ready), 32'd1);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      step();
      RESET     = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
            AW'($urandom_range(0, 7)), DW'($urandom));
      rsp_ready = 1'($urandom_range(0, 1));
    end
    step(); RESET = 1'b0; drive(0, 2'd0, '0, '0);
    repeat (4) step();
    @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
